// File: rtl/fdtd_mem_mover.sv
// Memory-side mover for the FDTD accelerator: streams old field words into the
// acc ram_buffer, fires the calc flag, then drains new words back to memory.
module fdtd_mem_mover #(
    parameter int FDTD_DATA_WIDTH   = 32,
    parameter int BUFFER_ADDR_WIDTH = 6,
    parameter int MEM_ADDR_WIDTH    = 32,
    parameter int SIZE_WIDTH        = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       start_i,
    input  logic [1:0]                 field_sel_i,
    input  logic [SIZE_WIDTH-1:0]      size_i,
    input  logic [MEM_ADDR_WIDTH-1:0]  src_base_i,
    input  logic [MEM_ADDR_WIDTH-1:0]  dst_base_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic                       mem_req_o,
    output logic                       mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]  mem_addr_o,
    output logic [FDTD_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                       mem_gnt_i,
    input  logic                       mem_rvalid_i,
    input  logic [FDTD_DATA_WIDTH-1:0] mem_rdata_i,
    output logic [FDTD_DATA_WIDTH-1:0] buffer_size_o,
    output logic                       buffer_Hy_start_o,
    output logic                       buffer_Ez_start_o,
    output logic                       buffer_src_start_o,
    output logic                       buffer_Hy_end_o,
    output logic                       buffer_Ez_end_o,
    output logic                       buffer_src_end_o,
    output logic                       wrtvalid_Hy_old_o,
    output logic                       wrtvalid_Ez_old_o,
    output logic [FDTD_DATA_WIDTH-1:0] Hy_old_o,
    output logic [FDTD_DATA_WIDTH-1:0] Ez_old_o,
    output logic                       calc_Hy_flg_o,
    output logic                       calc_Ez_flg_o,
    output logic                       calc_src_flg_o,
    input  logic                       wrt_Hy_start_i,
    input  logic                       wrt_Ez_start_i,
    input  logic                       wrt_src_start_i,
    output logic                       mem_rd_Hy_en_o,
    output logic                       mem_rd_Ez_en_o,
    output logic                       mem_rd_end_o,
    output logic                       wrtvalid_sgl_o,
    input  logic [FDTD_DATA_WIDTH-1:0] Hy_n_i,
    input  logic [FDTD_DATA_WIDTH-1:0] Ez_n_i,
    output logic [3:0]                 state_dbg
);

    // Memory handshake: mem_req_o with mem_we_o/mem_addr_o/mem_wdata_o is held
    // unchanged until a cycle with mem_gnt_i=1 (that cycle completes the
    // transfer); a granted read returns exactly one mem_rvalid_i cycle later on.
    localparam int DEPTH = 1 << BUFFER_ADDR_WIDTH;
    localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = 1;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LD_START = 4'd1,
        LD_REQ   = 4'd2,
        LD_WAIT  = 4'd3,
        LD_END   = 4'd4,
        CALC     = 4'd5,
        WB_WAIT  = 4'd6,
        WB_POP   = 4'd7,
        WB_CAP   = 4'd8,
        WB_REQ   = 4'd9,
        WB_END   = 4'd10,
        DONE     = 4'd11
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 sel_q, sel_d;
    logic [SIZE_WIDTH-1:0]      size_q, size_d;
    logic [SIZE_WIDTH-1:0]      idx_q, idx_d;
    logic [MEM_ADDR_WIDTH-1:0]  src_q, src_d;
    logic [MEM_ADDR_WIDTH-1:0]  dst_q, dst_d;

    logic                       busy_d, done_d, err_d;
    logic                       req_d, we_d;
    logic [MEM_ADDR_WIDTH-1:0]  addr_d;
    logic [FDTD_DATA_WIDTH-1:0] wdata_d, bsize_d, hy_old_d, ez_old_d;
    logic [2:0]                 bstart_q, bstart_d, bend_q, bend_d, calc_q, calc_d;
    logic [1:0]                 old_vld_q, old_vld_d, rd_en_q, rd_en_d;
    logic                       rd_end_d, sgl_d;

    logic is_ez, wrt_hit, last_word, size_bad;

    function automatic logic [MEM_ADDR_WIDTH-1:0] word_addr(
        input logic [MEM_ADDR_WIDTH-1:0] base,
        input logic [SIZE_WIDTH-1:0]     k
    );
        return base + MEM_ADDR_WIDTH'({k, 2'b00});
    endfunction

    // src jobs share the Ez data ports of the accelerator.
    assign is_ez     = (sel_q != 2'd0);
    assign wrt_hit   = (sel_q == 2'd0) ? wrt_Hy_start_i :
                       (sel_q == 2'd1) ? wrt_Ez_start_i : wrt_src_start_i;
    assign last_word = (idx_q == size_q - SIZE_ONE);
    assign size_bad  = (32'(size_i) > 32'(DEPTH));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        size_d    = size_q;
        idx_d     = idx_q;
        src_d     = src_q;
        dst_d     = dst_q;
        busy_d    = busy_o;
        done_d    = 1'b0;
        err_d     = 1'b0;
        req_d     = mem_req_o;
        we_d      = mem_we_o;
        addr_d    = mem_addr_o;
        wdata_d   = mem_wdata_o;
        bsize_d   = buffer_size_o;
        hy_old_d  = Hy_old_o;
        ez_old_d  = Ez_old_o;
        bstart_d  = 3'b000;
        bend_d    = 3'b000;
        calc_d    = 3'b000;
        old_vld_d = 2'b00;
        rd_en_d   = 2'b00;
        rd_end_d  = 1'b0;
        sgl_d     = 1'b0;

        // Outputs are loaded on the transition into a state, so each pulse
        // is visible for exactly the cycle spent in the state it belongs to.
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    sel_d  = field_sel_i;
                    size_d = size_i;
                    src_d  = src_base_i;
                    dst_d  = dst_base_i;
                    idx_d  = '0;
                    if (field_sel_i == 2'd3 || size_bad) begin
                        err_d = 1'b1;
                    end else if (size_i == '0) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d               = LD_START;
                        busy_d                = 1'b1;
                        bstart_d[field_sel_i] = 1'b1;
                        bsize_d               = FDTD_DATA_WIDTH'(size_i);
                    end
                end
            end
            LD_START: begin
                state_d = LD_REQ;
                req_d   = 1'b1;
                we_d    = 1'b0;
                addr_d  = word_addr(src_q, idx_q);
            end
            LD_REQ: begin
                if (mem_gnt_i) begin
                    req_d   = 1'b0;
                    state_d = LD_WAIT;
                end
            end
            LD_WAIT: begin
                if (mem_rvalid_i) begin
                    old_vld_d[is_ez] = 1'b1;
                    if (is_ez) ez_old_d = mem_rdata_i;
                    else       hy_old_d = mem_rdata_i;
                    if (last_word) begin
                        state_d       = LD_END;
                        bend_d[sel_q] = 1'b1;
                        idx_d         = '0;
                    end else begin
                        idx_d   = idx_q + SIZE_ONE;
                        state_d = LD_REQ;
                        req_d   = 1'b1;
                        we_d    = 1'b0;
                        addr_d  = word_addr(src_q, idx_q + SIZE_ONE);
                    end
                end
            end
            LD_END: begin
                state_d       = CALC;
                calc_d[sel_q] = 1'b1;
            end
            CALC: state_d = WB_WAIT;
            WB_WAIT: begin
                if (wrt_hit) begin
                    state_d        = WB_POP;
                    rd_en_d[is_ez] = 1'b1;
                end
            end
            WB_POP: state_d = WB_CAP;
            WB_CAP: begin
                wdata_d = is_ez ? Ez_n_i : Hy_n_i;
                state_d = WB_REQ;
                req_d   = 1'b1;
                we_d    = 1'b1;
                addr_d  = word_addr(dst_q, idx_q);
            end
            WB_REQ: begin
                if (mem_gnt_i) begin
                    req_d = 1'b0;
                    we_d  = 1'b0;
                    sgl_d = 1'b1;
                    if (last_word) begin
                        state_d  = WB_END;
                        rd_end_d = 1'b1;
                    end else begin
                        idx_d          = idx_q + SIZE_ONE;
                        state_d        = WB_POP;
                        rd_en_d[is_ez] = 1'b1;
                    end
                end
            end
            WB_END: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            size_q        <= '0;
            idx_q         <= '0;
            src_q         <= '0;
            dst_q         <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_we_o      <= 1'b0;
            mem_addr_o    <= '0;
            mem_wdata_o   <= '0;
            buffer_size_o <= '0;
            Hy_old_o      <= '0;
            Ez_old_o      <= '0;
            bstart_q      <= '0;
            bend_q        <= '0;
            calc_q        <= '0;
            old_vld_q     <= '0;
            rd_en_q       <= '0;
            mem_rd_end_o  <= 1'b0;
            wrtvalid_sgl_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            size_q        <= size_d;
            idx_q         <= idx_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            busy_o        <= busy_d;
            done_o        <= done_d;
            err_o         <= err_d;
            mem_req_o     <= req_d;
            mem_we_o      <= we_d;
            mem_addr_o    <= addr_d;
            mem_wdata_o   <= wdata_d;
            buffer_size_o <= bsize_d;
            Hy_old_o      <= hy_old_d;
            Ez_old_o      <= ez_old_d;
            bstart_q      <= bstart_d;
            bend_q        <= bend_d;
            calc_q        <= calc_d;
            old_vld_q     <= old_vld_d;
            rd_en_q       <= rd_en_d;
            mem_rd_end_o  <= rd_end_d;
            wrtvalid_sgl_o <= sgl_d;
        end
    end

    assign buffer_Hy_start_o  = bstart_q[0];
    assign buffer_Ez_start_o  = bstart_q[1];
    assign buffer_src_start_o = bstart_q[2];
    assign buffer_Hy_end_o    = bend_q[0];
    assign buffer_Ez_end_o    = bend_q[1];
    assign buffer_src_end_o   = bend_q[2];
    assign calc_Hy_flg_o      = calc_q[0];
    assign calc_Ez_flg_o      = calc_q[1];
    assign calc_src_flg_o     = calc_q[2];
    assign wrtvalid_Hy_old_o  = old_vld_q[0];
    assign wrtvalid_Ez_old_o  = old_vld_q[1];
    assign mem_rd_Hy_en_o     = rd_en_q[0];
    assign mem_rd_Ez_en_o     = rd_en_q[1];
    assign state_dbg          = state_q;

endmodule

// File: doc/fdtd_mem_mover.md
Name: fdtd_mem_mover

Overview:
- Memory-side companion to the FDTD accelerator. It streams old field words from data memory into the accelerator's ram_buffer.
- It then issues the calculation flag for the selected field.
- It drains the new field words back from the buffer and writes them to data memory.
- It sits between the accelerator and a single-outstanding SRAM-style memory port: it drives the acc's buffer, calc and readback control inputs and consumes its wrt_*_start and *_n outputs.

Parameters:
- FDTD_DATA_WIDTH, 32, field word width.
- BUFFER_ADDR_WIDTH, 6, acc buffer depth is 2**BUFFER_ADDR_WIDTH words.
- MEM_ADDR_WIDTH, 32, byte address width.
- SIZE_WIDTH, 16, width of the transfer length.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- start_i  in  1  command pulse; accepted only in IDLE.
- field_sel_i  in  2  0=Hy, 1=Ez, 2=src (Ez buffers), 3=illegal.
- size_i  in  SIZE_WIDTH  word count.
- src_base_i  in  MEM_ADDR_WIDTH  old-field base byte address.
- dst_base_i  in  MEM_ADDR_WIDTH  new-field base byte address.
- busy_o  out  1  high from accept until done.
- done_o  out  1  1-cycle completion pulse.
- err_o  out  1  1-cycle pulse on rejected command.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  1=write.
- mem_addr_o  out  MEM_ADDR_WIDTH  byte address.
- mem_wdata_o  out  FDTD_DATA_WIDTH  write data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  FDTD_DATA_WIDTH  read data.
- buffer_size_o  out  FDTD_DATA_WIDTH  zero-extended latched size.
- buffer_Hy_start_o / buffer_Ez_start_o / buffer_src_start_o  out  1 each.
- buffer_Hy_end_o / buffer_Ez_end_o / buffer_src_end_o  out  1 each.
- wrtvalid_Hy_old_o / wrtvalid_Ez_old_o  out  1 each.
- Hy_old_o / Ez_old_o  out  FDTD_DATA_WIDTH each.
- calc_Hy_flg_o / calc_Ez_flg_o / calc_src_flg_o  out  1 each.
- wrt_Hy_start_i / wrt_Ez_start_i / wrt_src_start_i  in  1 each.
- mem_rd_Hy_en_o / mem_rd_Ez_en_o  out  1 each.
- mem_rd_end_o  out  1.
- wrtvalid_sgl_o  out  1.
- Hy_n_i / Ez_n_i  in  FDTD_DATA_WIDTH each.

Behaviour:
- Reset: all outputs 0; state IDLE; counters cleared. RST mid-operation aborts immediately, with no done_o pulse and no further memory requests. All outputs are registered.
- Command accept (IDLE, start_i=1): latch field_sel_i, size_i and both bases; clear index i; set busy_o.
  - Illegal select, or size_i > 2**BUFFER_ADDR_WIDTH: err_o pulses next cycle, busy_o stays 0, return to IDLE.
  - size_i=0: done_o pulses next cycle; no buffer, calc or memory activity.
  - start_i outside IDLE is ignored.
- States: IDLE -> LD_START -> LD_REQ <-> LD_WAIT -> LD_END -> CALC -> WB_WAIT -> WB_POP -> WB_CAP -> WB_REQ -> (WB_POP | WB_END) -> DONE -> IDLE.
- LD_START: pulse buffer_<f>_start_o for 1 cycle (f = Hy, Ez or src); set buffer_size_o.
- LD_REQ: mem_req_o=1, mem_we_o=0, mem_addr_o=src_base+4*i. Request stays stable until mem_gnt_i, then go to LD_WAIT.
- LD_WAIT: on mem_rvalid_i, drive Hy_old_o (sel 0) or Ez_old_o (sel 1/2) with mem_rdata_i and pulse wrtvalid_<Hy|Ez>_old_o for 1 cycle, then i++.
  - If i == size-1 go to LD_END, else go to LD_REQ.
  - At most one outstanding read.
- LD_END: pulse buffer_<f>_end_o; clear i.
- CALC: pulse calc_<f>_flg_o for 1 cycle.
- WB_WAIT: wait for wrt_<f>_start_i with no timeout. wrt_*_start_i for a non-selected field is ignored.
- WB_POP: pulse mem_rd_<Hy|Ez>_en_o for 1 cycle.
- WB_CAP: the accelerator presents *_n_i one cycle after the pop; capture it into mem_wdata_o.
- WB_REQ: mem_req_o=1, mem_we_o=1, mem_addr_o=dst_base+4*i. On mem_gnt_i, pulse wrtvalid_sgl_o and i++. If i == size-1 go to WB_END, else go to WB_POP.
- WB_END: pulse mem_rd_end_o.
- DONE: pulse done_o; clear busy_o.
- Address arithmetic is modulo 2**MEM_ADDR_WIDTH (wrap allowed).
- mem_rvalid_i outside LD_WAIT is ignored.
- mem_gnt_i while mem_req_o=0 is ignored.

Test Plan:
- Hy, size=4, src=0x100, dst=0x200, gnt immediate, rvalid 1 cycle later:
  - reads issued at 0x100/104/108/10C;
  - 4 wrtvalid_Hy_old_o pulses with the matching data;
  - buffer_Hy_start/end pulses and one calc_Hy_flg_o;
  - after wrt_Hy_start_i: 4 mem_rd_Hy_en_o pulses, writes to 0x200..0x20C of Hy_n_i values, 4 wrtvalid_sgl_o pulses;
  - then mem_rd_end_o, then done_o.
- src, size=2, mem_gnt_i delayed 3 cycles per request: address and data held stable while waiting; Ez ports used; buffer_src_* and calc_src_flg_o pulse once each.
- size=0 -> done_o exactly 1 cycle after start, zero mem_req_o. field_sel=3 -> err_o pulse, busy_o stays 0. size=65 with BUFFER_ADDR_WIDTH=6 -> err_o pulse.
- Ez, size=64 (full buffer): exactly 64 reads and 64 writes; i reaches 63 with no overrun.
- start_i reasserted while busy -> ignored; wrt_Hy_start_i during an Ez job -> ignored.
- RST asserted mid-LD_WAIT -> next cycle every output is 0 and state is IDLE; a new start then completes normally.
